// File: rtl/prog_loader_if.sv
// prog_loader_if -- host byte stream and CPU memory read bus of the program loader.
//
// Signals:
//   start     host -> loader  single-cycle request to begin a program load
//   in_valid  host -> loader  byte-stream valid
//   in_data   host -> loader  byte-stream payload (8 bits)
//   in_ready  loader -> host  loader accepts a byte (transfer = in_valid & in_ready)
//   cpu_addr  CPU  -> loader  program memory address (4 bits)
//   cpu_ce_n  CPU  -> loader  memory enable, active-low
//   cpu_data  loader -> CPU   read data (8 bits)
//
// Modports: master = host/CPU side, slave = loader side.
interface prog_loader_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic       cpu_ce_n;
  logic [7:0] cpu_data;

  modport master (
    output start, in_valid, in_data, cpu_addr, cpu_ce_n,
    input  in_ready, cpu_data
  );

  modport slave (
    input  start, in_valid, in_data, cpu_addr, cpu_ce_n,
    output in_ready, cpu_data
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- loads a 16-byte program from a host byte stream into a
// 16 x 8 program memory, holds the CPU in reset while loading, then releases it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   bus        prog_loader_if.slave (host stream + CPU read bus)
//   o_cpu_rst  registered hold-reset to the CPU, active-high
//   o_busy     high while loading (LOAD/CHECK)
//   o_done     high while the CPU runs (RUN)
//   o_err      high on checksum failure (ERR); tied low without checksum
//
// Configuration macro: PROG_LOADER_CHECKSUM_EN
//   defined   : after the 16 data bytes one checksum byte is accepted;
//               (sum + byte) mod 256 == 0 enters RUN, otherwise ERR.
//   undefined : LOAD goes straight to RUN, no CHECK/ERR states.
module prog_loader (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus,
  output logic         o_cpu_rst,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Running byte sum, mod 256
  function automatic logic [7:0] sum_add(input logic [7:0] sum, input logic [7:0] b);
    logic [7:0] t;
    t = sum + b;
    return t;
  endfunction

  // Checksum byte is valid when it brings the running sum to zero
  function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] b);
    return (sum_add(sum, b) == 8'h00);
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_mem [16];
  logic [3:0] r_wr_ptr;
  logic       r_in_ready;
  logic       r_busy;
  logic       r_done;
  logic       r_cpu_rst;
  logic       w_fire;
  logic       w_tc;
  logic       w_wr_en;
  logic       w_restart;
  logic       w_loading_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
`endif

  // in_ready is registered, so a transfer never depends combinationally on in_valid
  assign w_fire = bus.in_valid & r_in_ready;
  // Terminal count: the byte being accepted is the 16th
  assign w_tc   = (r_wr_ptr == 4'd15);

  // Next-state, memory write enable and load restart decode
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_LOAD;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_fire) begin
          w_wr_en = 1'b1;
          if (w_tc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CHECK;
`else
            w_state_nxt = ST_RUN;
`endif
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_fire) begin
          if (checksum_ok(r_sum, bus.in_data)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_ERR: begin
        if (bus.start) begin
          w_state_nxt = ST_LOAD;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = ST_ERR;
        end
      end
`endif
      ST_RUN: begin
        if (bus.start) begin
          w_state_nxt = ST_LOAD;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Accepting bytes in the state being entered (LOAD, or CHECK when built)
  always_comb begin
`ifdef PROG_LOADER_CHECKSUM_EN
    w_loading_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
`else
    w_loading_nxt = (w_state_nxt == ST_LOAD);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs decoded from the state being entered, so they change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_in_ready <= w_loading_nxt;
      r_busy     <= w_loading_nxt;
      r_done     <= (w_state_nxt == ST_RUN);
      r_cpu_rst  <= (w_state_nxt != ST_RUN);
    end
  end

  // Write pointer: cleared on each new load, wraps to 0 after the 16th byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 4'd0;
    end else if (w_restart) begin
      r_wr_ptr <= 4'd0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 4'd1;
    end
  end

  // Program memory: reset fills every word with HLT (8'hFF)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 8'hFF;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running checksum over the 16 data bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= 8'h00;
    end else if (w_restart) begin
      r_sum <= 8'h00;
    end else if (w_wr_en) begin
      r_sum <= sum_add(r_sum, bus.in_data);
    end
  end

  // Error flag, held until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == ST_ERR);
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  // CPU read port: asynchronous read, so a same-cycle write is seen only after the edge
  assign bus.cpu_data = bus.cpu_ce_n ? 8'h00 : r_mem[bus.cpu_addr];
  assign bus.in_ready = r_in_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cpu_rst    = r_cpu_rst;

endmodule
